// File: rtl/serializer_pkg.sv
// ----------------------------------------------------------------------------
// serializer_pkg
// Shared types and constants for the multi-rate frame serializer.
//   state_t     : serializer control states (RESET, IDLE, LOAD, SHIFT)
//   START_BIT   : level of the leading frame bit
//   STOP_BIT    : level of the trailing frame bit (also the idle line level)
//   frame_bits  : total bits on the wire for one frame
// ----------------------------------------------------------------------------
package serializer_pkg;

  typedef enum logic [1:0] {
    RESET = 2'd0,
    IDLE  = 2'd1,
    LOAD  = 2'd2,
    SHIFT = 2'd3
  } state_t;

  localparam logic START_BIT = 1'b1;
  localparam logic STOP_BIT  = 1'b0;

  // start + data + optional parity + stop
  function automatic int unsigned frame_bits(input int unsigned txn_sz, input logic parity_en);
    return txn_sz + 32'd2 + {31'd0, parity_en};
  endfunction

endpackage

// File: rtl/serializer_fifo.sv
// ----------------------------------------------------------------------------
// serializer_fifo
// Synchronous show-ahead FIFO holding words waiting to be serialized.
// Ports:
//   clock, reset : system clock, asynchronous active-high reset (flushes)
//   push, din    : write request and word; ignored while full
//   pop          : read request; ignored while empty
//   dout         : current head word (valid while !empty)
//   full, empty  : occupancy flags
//   count        : words currently stored
// ----------------------------------------------------------------------------
module serializer_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           push,
  input  logic                           pop,
  input  logic [WIDTH-1:0]               din,
  output logic [WIDTH-1:0]               dout,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == CW'(0));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy tracking; DEPTH is a power of two so pointers wrap naturally
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= AW'(0);
      rd_ptr <= AW'(0);
      count  <= CW'(0);
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Word storage; contents are don't-care until written, so no reset
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule

// File: rtl/multi_rate_serializer.sv
// ----------------------------------------------------------------------------
// multi_rate_serializer
// Buffers words and sends each one MSB-first as a frame:
//   start '1', data, optional parity, stop '0', each bit bit_div+1 clocks long.
// Ports:
//   clock, reset          : system clock, asynchronous active-high reset
//   data, nd, rdy         : enqueue word / request / FIFO-not-full
//   bit_div               : clocks per bit minus 1 (sampled in LOAD)
//   parity_en, parity_odd : parity insert / odd select (sampled in LOAD)
//   inject_perr           : only with SERIALIZER_PARITY_INJECT_EN defined;
//                           inverts the parity bit of the frame (sampled in LOAD)
//   sout                  : registered serial output, idle low
//   busy                  : controller not idle
//   fifo_count            : buffered words
//   ovf                   : one-clock pulse when a word is dropped (nd while !rdy)
// Build option: SERIALIZER_PARITY_INJECT_EN adds the inject_perr port.
// ----------------------------------------------------------------------------
module multi_rate_serializer
  import serializer_pkg::*;
#(
  parameter int TXN_SZ     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [TXN_SZ-1:0]                  data,
  input  logic                               nd,
  output logic                               rdy,
  input  logic [DIV_W-1:0]                   bit_div,
  input  logic                               parity_en,
  input  logic                               parity_odd,
`ifdef SERIALIZER_PARITY_INJECT_EN
  input  logic                               inject_perr,
`endif
  output logic                               sout,
  output logic                               busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
  output logic                               ovf
);

  // Shift register holds start + data + parity + one spare; zero fill supplies the stop bit
  localparam int SW  = TXN_SZ + 3;
  localparam int BCW = $clog2(TXN_SZ + 4);

  state_t              state, state_nx;
  logic [SW-1:0]       shreg, shreg_nx;
  logic [BCW-1:0]      bit_cnt, bit_cnt_nx;
  logic [DIV_W-1:0]    div_cnt, div_cnt_nx;
  logic [DIV_W-1:0]    div_rel, div_rel_nx;
  logic                sout_nx;
  logic                par;
  logic                pop;
  logic                push;
  logic                full;
  logic                empty;
  logic                inj;
  logic [TXN_SZ-1:0]   head;

  function automatic logic calc_parity(input logic [TXN_SZ-1:0] w, input logic odd);
    return (^w) ^ odd;
  endfunction

`ifdef SERIALIZER_PARITY_INJECT_EN
  assign inj = inject_perr;
`else
  assign inj = 1'b0;
`endif

  assign rdy  = (state != RESET) && !full;
  assign push = nd && rdy;
  assign busy = (state != IDLE);

  serializer_fifo #(
    .WIDTH (TXN_SZ),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (data),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  // Next-state, datapath and next-sout decode
  always_comb begin
    state_nx   = state;
    shreg_nx   = shreg;
    bit_cnt_nx = bit_cnt;
    div_cnt_nx = div_cnt;
    div_rel_nx = div_rel;
    sout_nx    = STOP_BIT;
    pop        = 1'b0;
    par        = 1'b0;
    case (state)
      RESET: begin
        state_nx = IDLE;
      end
      IDLE: begin
        if (!empty) begin
          state_nx = LOAD;
        end else begin
          state_nx = IDLE;
        end
      end
      LOAD: begin
        pop = 1'b1;
        par = calc_parity(head, parity_odd) ^ inj;
        if (parity_en) begin
          shreg_nx = {START_BIT, head, par, STOP_BIT};
        end else begin
          shreg_nx = {START_BIT, head, STOP_BIT, STOP_BIT};
        end
        bit_cnt_nx = BCW'(frame_bits(TXN_SZ, parity_en) - 32'd1);
        div_cnt_nx = bit_div;
        div_rel_nx = bit_div;
        sout_nx    = START_BIT;
        state_nx   = SHIFT;
      end
      SHIFT: begin
        if (div_cnt == DIV_W'(0)) begin
          div_cnt_nx = div_rel;
          shreg_nx   = {shreg[SW-2:0], 1'b0};
          if (bit_cnt == BCW'(0)) begin
            // end of stop bit: line stays low through the next LOAD or idle
            sout_nx = STOP_BIT;
            if (!empty) begin
              state_nx = LOAD;
            end else begin
              state_nx = IDLE;
            end
          end else begin
            bit_cnt_nx = bit_cnt - BCW'(1);
            sout_nx    = shreg[SW-2];
          end
        end else begin
          div_cnt_nx = div_cnt - DIV_W'(1);
          sout_nx    = shreg[SW-1];
        end
      end
      default: begin
        state_nx = RESET;
      end
    endcase
  end

  // Control and datapath registers, including the registered serial output
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= RESET;
      shreg   <= SW'(0);
      bit_cnt <= BCW'(0);
      div_cnt <= DIV_W'(0);
      div_rel <= DIV_W'(0);
      sout    <= STOP_BIT;
      ovf     <= 1'b0;
    end else begin
      state   <= state_nx;
      shreg   <= shreg_nx;
      bit_cnt <= bit_cnt_nx;
      div_cnt <= div_cnt_nx;
      div_rel <= div_rel_nx;
      sout    <= sout_nx;
      ovf     <= nd && !rdy;
    end
  end

endmodule

// File: tb/tb_multi_rate_serializer.sv
// ----------------------------------------------------------------------------
// tb_multi_rate_serializer
// Directed bench: each push queues the expected frame; a negedge monitor
// expands it into per-clock sout levels and compares as the frame is sent.
// ----------------------------------------------------------------------------
module tb_multi_rate_serializer;

  logic        clock = 1'b0;
  logic        reset;
  logic        nd;
  logic [7:0]  data;
  logic        rdy;
  logic [15:0] bit_div;
  logic        parity_en;
  logic        parity_odd;
  logic        inject_perr;
  logic        sout;
  logic        busy;
  logic [2:0]  fifo_count;
  logic        ovf;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] d;
    bit         pen;
    bit         podd;
    bit         inj;
    int         div;
    int         gap;   // expected low clocks (stop bit + LOAD) before start; -1 = unchecked
  } frame_t;

  frame_t sb[$];
  bit     active      = 1'b0;
  int     mon_pos     = 0;
  int     low_run     = 0;
  int     frames_seen = 0;
  bit     exp_seq[$];

  multi_rate_serializer #(
    .TXN_SZ     (8),
    .FIFO_DEPTH (4),
    .DIV_W      (16)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .data        (data),
    .nd          (nd),
    .rdy         (rdy),
    .bit_div     (bit_div),
    .parity_en   (parity_en),
    .parity_odd  (parity_odd),
`ifdef SERIALIZER_PARITY_INJECT_EN
    .inject_perr (inject_perr),
`endif
    .sout        (sout),
    .busy        (busy),
    .fifo_count  (fifo_count),
    .ovf         (ovf)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [7:0] d, input bit pen, input bit podd,
                           input bit inj, input int div, input int gap);
    frame_t f;
    f.d = d; f.pen = pen; f.podd = podd; f.inj = inj; f.div = div; f.gap = gap;
    sb.push_back(f);
    nd   = 1'b1;
    data = d;
    @(negedge clock);
    nd   = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    bit done;
    done = 1'b0;
    for (int i = 0; i < limit && !done; i++) begin
      @(posedge clock);
      #1;
      if (busy === 1'b0 && sb.size() == 0 && !active) done = 1'b1;
    end
    chk("wait_idle", 32'(done), 32'd1);
    @(negedge clock);
  endtask

  // Monitor: expand expected frames into per-clock levels and compare sout
  initial begin
    frame_t cur;
    bit     fb[$];
    forever begin
      @(negedge clock);
      if (reset !== 1'b0) begin
        active  = 1'b0;
        mon_pos = 0;
        low_run = 0;
      end else begin
        if (!active) begin
          if (sout === 1'b1) begin
            chk("frame_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
              cur = sb.pop_front();
              fb.delete();
              fb.push_back(1'b1);
              for (int i = 7; i >= 0; i--) fb.push_back(cur.d[i]);
              if (cur.pen) fb.push_back((^cur.d) ^ cur.podd ^ cur.inj);
              fb.push_back(1'b0);
              exp_seq.delete();
              foreach (fb[k]) for (int r = 0; r <= cur.div; r++) exp_seq.push_back(fb[k]);
              if (cur.gap >= 0) chk($sformatf("gap_d%0h", cur.d), 32'(low_run), 32'(cur.gap));
              active  = 1'b1;
              mon_pos = 0;
              frames_seen++;
            end
          end else begin
            low_run++;
          end
        end
        if (active) begin
          chk($sformatf("sout_d%0h_clk%0d", cur.d, mon_pos), 32'(sout), 32'(exp_seq[mon_pos]));
          mon_pos++;
          if (mon_pos == exp_seq.size()) begin
            active  = 1'b0;
            low_run = cur.div + 1;   // stop-bit clocks already seen low
          end
        end
      end
    end
  end

  // Watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    bit reached;
    int seen_before;
    reset = 1'b1; nd = 1'b0; data = 8'h00; bit_div = 16'd0;
    parity_en = 1'b1; parity_odd = 1'b0; inject_perr = 1'b0;

    // Reset state
    @(negedge clock);
    chk("rst_rdy",   32'(rdy), 32'd0);
    chk("rst_busy",  32'(busy), 32'd1);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_sout",  32'(sout), 32'd0);
    chk("rst_ovf",   32'(ovf), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_rdy",  32'(rdy), 32'd1);

    // Frame format and latency: A5, even parity, one clock per bit
    push_word(8'hA5, 1'b1, 1'b0, 1'b0, 0, -1);
    chk("t1_count", 32'(fifo_count), 32'd1);
    @(negedge clock);
    chk("t1_lat_e1", 32'(sout), 32'd0);
    @(negedge clock);
    chk("t1_lat_e2", 32'(sout), 32'd1);
    wait_idle(100);
    chk("t1_busy", 32'(busy), 32'd0);

    // Divider with odd then even parity
    bit_div = 16'd3; parity_odd = 1'b1;
    push_word(8'h01, 1'b1, 1'b1, 1'b0, 3, -1);
    wait_idle(200);
    parity_odd = 1'b0;
    push_word(8'h01, 1'b1, 1'b0, 1'b0, 3, -1);
    wait_idle(200);

    // Buffering, full flag, overflow drop, inter-frame gap
    bit_div = 16'd1;
    push_word(8'h11, 1'b1, 1'b0, 1'b0, 1, -1);
    repeat (4) @(negedge clock);
    push_word(8'h22, 1'b1, 1'b0, 1'b0, 1, 3);
    push_word(8'h33, 1'b1, 1'b0, 1'b0, 1, 3);
    push_word(8'h44, 1'b1, 1'b0, 1'b0, 1, 3);
    push_word(8'h55, 1'b1, 1'b0, 1'b0, 1, 3);
    chk("t3_rdy_full", 32'(rdy), 32'd0);
    chk("t3_count4",   32'(fifo_count), 32'd4);
    nd = 1'b1; data = 8'hEE;
    @(negedge clock);
    nd = 1'b0;
    chk("t3_ovf_pulse", 32'(ovf), 32'd1);
    @(negedge clock);
    chk("t3_ovf_clear", 32'(ovf), 32'd0);
    chk("t3_count_kept", 32'(fifo_count), 32'd4);
    wait_idle(500);

    // No parity; bit_div changed mid-frame only affects the next frame
    parity_en = 1'b0; bit_div = 16'd0;
    push_word(8'h3C, 1'b0, 1'b0, 1'b0, 0, -1);
    push_word(8'hC3, 1'b0, 1'b0, 1'b0, 2, 2);
    repeat (3) @(negedge clock);
    bit_div = 16'd2;
    wait_idle(200);

    // Reset mid-frame with two words queued
    parity_en = 1'b1; bit_div = 16'd0;
    push_word(8'hF0, 1'b1, 1'b0, 1'b0, 0, -1);
    push_word(8'h0F, 1'b1, 1'b0, 1'b0, 0, -1);
    push_word(8'h5A, 1'b1, 1'b0, 1'b0, 0, -1);
    for (int i = 0; i < 40 && !(active && mon_pos >= 6); i++) @(posedge clock);
    reached = active && (mon_pos >= 6);
    chk("t5_mid_frame_reached", 32'(reached), 32'd1);
    #2;
    reset = 1'b1;
    sb.delete();
    #1;
    chk("t5_async_sout",  32'(sout), 32'd0);
    chk("t5_async_count", 32'(fifo_count), 32'd0);
    chk("t5_async_busy",  32'(busy), 32'd1);
    chk("t5_async_rdy",   32'(rdy), 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    seen_before = frames_seen;
    repeat (30) @(negedge clock);
    chk("t5_no_frames", 32'(frames_seen), 32'(seen_before));
    chk("t5_count0",    32'(fifo_count), 32'd0);
    chk("t5_idle",      32'(busy), 32'd0);
    chk("t5_sout_low",  32'(sout), 32'd0);
    push_word(8'h96, 1'b1, 1'b0, 1'b0, 0, -1);
    wait_idle(100);

`ifdef SERIALIZER_PARITY_INJECT_EN
    // Parity error injection, then a clean frame, then injection with parity off
    parity_en = 1'b1; parity_odd = 1'b0; bit_div = 16'd0; inject_perr = 1'b1;
    push_word(8'hA5, 1'b1, 1'b0, 1'b1, 0, -1);
    wait_idle(100);
    inject_perr = 1'b0;
    push_word(8'hA5, 1'b1, 1'b0, 1'b0, 0, -1);
    wait_idle(100);
    parity_en = 1'b0; inject_perr = 1'b1;
    push_word(8'h3C, 1'b0, 1'b0, 1'b1, 0, -1);
    wait_idle(100);
    inject_perr = 1'b0;
`endif

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
